// File: rtl/semaforo_pkg.sv
// rtl/semaforo_pkg.sv - light codes, controller state encoding and output decode helpers
package semaforo_pkg;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;
    localparam logic [1:0] OFF    = 2'b11;

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_START  = 3'd1,
        S_MAIN_G = 3'd2,
        S_MAIN_Y = 3'd3,
        S_CLR1   = 3'd4,
        S_SIDE_G = 3'd5,
        S_SIDE_Y = 3'd6,
        S_CLR2   = 3'd7
    } state_t;

    function automatic logic [1:0] main_code(input state_t s);
        case (s)
            S_OFF:    main_code = OFF;
            S_MAIN_G: main_code = GREEN;
            S_MAIN_Y: main_code = YELLOW;
            default:  main_code = RED;
        endcase
    endfunction

    function automatic logic [1:0] side_code(input state_t s);
        case (s)
            S_OFF:    side_code = OFF;
            S_SIDE_G: side_code = GREEN;
            S_SIDE_Y: side_code = YELLOW;
            default:  side_code = RED;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - saturating phase counter with synchronous clear and duration compare
module phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] dur,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (count != {CNT_W{1'b1}}) begin
            count <= count + ONE;
        end
    end

    // >= rather than == so the main-green minimum keeps qualifying after saturation
    assign done = (count >= (dur - ONE));

endmodule

// File: rtl/semaforo_ctrl.sv
// rtl/semaforo_ctrl.sv - main/side intersection sequencer with latched vehicle and pedestrian requests
module semaforo_ctrl
    import semaforo_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int T_MAIN_MIN = 10000,
    parameter int T_SIDE     = 8000,
    parameter int T_YELLOW   = 3000,
    parameter int T_ALLRED   = 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic       side_req,
    input  logic       ped_req,
    output logic [1:0] main_light,
    output logic [1:0] side_light,
    output logic       ped_walk
);

    localparam logic [CNT_W-1:0] D_MAIN   = CNT_W'(T_MAIN_MIN);
    localparam logic [CNT_W-1:0] D_SIDE   = CNT_W'(T_SIDE);
    localparam logic [CNT_W-1:0] D_YELLOW = CNT_W'(T_YELLOW);
    localparam logic [CNT_W-1:0] D_ALLRED = CNT_W'(T_ALLRED);

    state_t           state_q, state_next;
    logic [CNT_W-1:0] dur;
    logic [CNT_W-1:0] count;
    logic             done;
    logic             load;
    logic             side_pend, ped_pend, walk_q;
    logic             side_pend_next, ped_pend_next, walk_next;
    logic             clr_edge;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .dur     (dur),
        .count   (count),
        .done    (done)
    );

    always_comb begin
        dur = D_ALLRED;
        case (state_q)
            S_MAIN_G:           dur = D_MAIN;
            S_SIDE_G:           dur = D_SIDE;
            S_MAIN_Y, S_SIDE_Y: dur = D_YELLOW;
            default:            dur = D_ALLRED;
        endcase
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            S_OFF:    if (en) state_next = S_START;
            S_START:  if (done) state_next = S_MAIN_G;
            S_MAIN_G: if (done && (side_pend || ped_pend)) state_next = S_MAIN_Y;
            S_MAIN_Y: if (done) state_next = S_CLR1;
            S_CLR1:   if (done) state_next = S_SIDE_G;
            S_SIDE_G: if (done) state_next = S_SIDE_Y;
            S_SIDE_Y: if (done) state_next = S_CLR2;
            S_CLR2:   if (done) state_next = S_MAIN_G;
            default:  state_next = S_OFF;
        endcase
        if (!en) state_next = S_OFF;
    end

    // S_OFF keeps the counter cleared so every restart begins from zero
    assign load     = (state_next != state_q) || (state_q == S_OFF);
    assign clr_edge = (state_q == S_CLR1) && (state_next == S_SIDE_G);

    // A request coinciding with the clear edge wins, so it is served by the next cycle
    always_comb begin
        side_pend_next = side_pend;
        ped_pend_next  = ped_pend;
        walk_next      = walk_q;
        if (state_q == S_OFF) begin
            side_pend_next = 1'b0;
            ped_pend_next  = 1'b0;
        end else begin
            if (clr_edge) begin
                side_pend_next = 1'b0;
                ped_pend_next  = 1'b0;
                walk_next      = ped_pend;
            end
            if (side_req) side_pend_next = 1'b1;
            if (ped_req)  ped_pend_next  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_OFF;
            side_pend  <= 1'b0;
            ped_pend   <= 1'b0;
            walk_q     <= 1'b0;
            main_light <= OFF;
            side_light <= OFF;
            ped_walk   <= 1'b0;
        end else begin
            state_q    <= state_next;
            side_pend  <= side_pend_next;
            ped_pend   <= ped_pend_next;
            walk_q     <= walk_next;
            main_light <= main_code(state_next);
            side_light <= side_code(state_next);
            ped_walk   <= (state_next == S_SIDE_G) && walk_next;
        end
    end

endmodule

// File: tb/tb_semaforo_ctrl.sv
// tb/tb_semaforo_ctrl.sv - directed self-checking bench for semaforo_ctrl
module tb_semaforo_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic       side_req = 1'b0;
    logic       ped_req = 1'b0;
    logic [1:0] main_light;
    logic [1:0] side_light;
    logic       ped_walk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // {main, side, walk}
    localparam logic [4:0] OO  = 5'b11_11_0;
    localparam logic [4:0] RR  = 5'b00_00_0;
    localparam logic [4:0] GR  = 5'b10_00_0;
    localparam logic [4:0] YR  = 5'b01_00_0;
    localparam logic [4:0] RG  = 5'b00_10_0;
    localparam logic [4:0] RGW = 5'b00_10_1;
    localparam logic [4:0] RY  = 5'b00_01_0;

    semaforo_ctrl #(
        .CNT_W      (16),
        .T_MAIN_MIN (4),
        .T_SIDE     (3),
        .T_YELLOW   (2),
        .T_ALLRED   (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .side_req   (side_req),
        .ped_req    (ped_req),
        .main_light (main_light),
        .side_light (side_light),
        .ped_walk   (ped_walk)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        en = 1'b0;
        tick();
        tick();
        total_cnt++;
        if ({main_light, side_light, ped_walk} !== OO)
            $display("FAIL reset_outputs got=%b exp=%b", {main_light, side_light, ped_walk}, OO);
        else pass_cnt++;
        reset_n = 1'b1;
        tick();
        total_cnt++;
        if ({main_light, side_light, ped_walk} !== OO)
            $display("FAIL off_without_en got=%b exp=%b", {main_light, side_light, ped_walk}, OO);
        else pass_cnt++;
    endtask

    task automatic test_idle_green();
        en = 1'b1;
        tick();
        total_cnt++;
        if ({main_light, side_light, ped_walk} !== RR)
            $display("FAIL start_allred got=%b exp=%b", {main_light, side_light, ped_walk}, RR);
        else pass_cnt++;
        for (int i = 0; i < 51; i++) begin
            tick();
            total_cnt++;
            if ({main_light, side_light, ped_walk} !== GR)
                $display("FAIL idle_green cyc=%0d got=%b exp=%b", i, {main_light, side_light, ped_walk}, GR);
            else pass_cnt++;
        end
    endtask

    task automatic test_side_req();
        logic [4:0] exp_seq [11];
        exp_seq = '{GR, YR, YR, RR, RG, RG, RG, RY, RY, RR, GR};
        side_req = 1'b1;
        tick();
        side_req = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (i > 0) tick();
            total_cnt++;
            if ({main_light, side_light, ped_walk} !== exp_seq[i])
                $display("FAIL side_cycle step=%0d got=%b exp=%b", i, {main_light, side_light, ped_walk}, exp_seq[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_ped_req();
        logic [4:0] exp_seq [13];
        exp_seq = '{GR, GR, GR, YR, YR, RR, RGW, RGW, RGW, RY, RY, RR, GR};
        ped_req = 1'b1;
        tick();
        ped_req = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (i > 0) tick();
            total_cnt++;
            if ({main_light, side_light, ped_walk} !== exp_seq[i])
                $display("FAIL ped_cycle step=%0d got=%b exp=%b", i, {main_light, side_light, ped_walk}, exp_seq[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] pre_seq [7];
        logic [4:0] post_seq [10];
        pre_seq  = '{GR, GR, GR, YR, YR, RR, RG};
        post_seq = '{RG, RG, RY, RY, RR, GR, GR, GR, GR, YR};
        side_req = 1'b1;
        tick();
        side_req = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            total_cnt++;
            if ({main_light, side_light, ped_walk} !== pre_seq[i])
                $display("FAIL b2b_first step=%0d got=%b exp=%b", i, {main_light, side_light, ped_walk}, pre_seq[i]);
            else pass_cnt++;
        end
        side_req = 1'b1;
        tick();
        side_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick();
            total_cnt++;
            if ({main_light, side_light, ped_walk} !== post_seq[i])
                $display("FAIL b2b_second step=%0d got=%b exp=%b", i, {main_light, side_light, ped_walk}, post_seq[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_en_drop();
        en = 1'b0;
        tick();
        total_cnt++;
        if ({main_light, side_light, ped_walk} !== OO)
            $display("FAIL en_drop got=%b exp=%b", {main_light, side_light, ped_walk}, OO);
        else pass_cnt++;
        tick();
        en = 1'b1;
        tick();
        total_cnt++;
        if ({main_light, side_light, ped_walk} !== RR)
            $display("FAIL en_restart got=%b exp=%b", {main_light, side_light, ped_walk}, RR);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            tick();
            total_cnt++;
            if ({main_light, side_light, ped_walk} !== GR)
                $display("FAIL pend_cleared cyc=%0d got=%b exp=%b", i, {main_light, side_light, ped_walk}, GR);
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        side_req = 1'b1;
        tick();
        side_req = 1'b0;
        tick();
        tick();
        tick();
        tick();
        total_cnt++;
        if ({main_light, side_light, ped_walk} !== RG)
            $display("FAIL pre_reset_side_green got=%b exp=%b", {main_light, side_light, ped_walk}, RG);
        else pass_cnt++;
        #2;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({main_light, side_light, ped_walk} !== OO)
            $display("FAIL async_reset got=%b exp=%b", {main_light, side_light, ped_walk}, OO);
        else pass_cnt++;
        tick();
        reset_n = 1'b1;
        tick();
        total_cnt++;
        if ({main_light, side_light, ped_walk} !== RR)
            $display("FAIL post_reset_start got=%b exp=%b", {main_light, side_light, ped_walk}, RR);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_idle_green();
        test_side_req();
        test_ped_req();
        test_back_to_back();
        test_en_drop();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
